// File: rtl/pipelined_write_rx.sv
// Pipelined write receiver: one command cycle plus up to MAX_WR_CYCLES
// data beats, rebuilt into a single wide write with error and done pulses.
module pipelined_write_rx #(
  parameter int WR_WIDTH      = 8,
  parameter int MAX_WR_CYCLES = 4,
  parameter int NCW           = $clog2(MAX_WR_CYCLES)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [WR_WIDTH+1:0]               in_cyc,
  output logic                              wr_vld,
  input  logic                              wr_rdy,
  output logic [MAX_WR_CYCLES*WR_WIDTH-1:0] wr_dat,
  output logic [NCW:0]                      wr_num_cycles,
  output logic [2:0]                        wr_type,
  output logic                              wdone,
  output logic                              err,
  output logic [1:0]                        err_code,
  output logic                              ovf
);

  localparam int DW = MAX_WR_CYCLES * WR_WIDTH;

  if (1 + NCW + 3 > WR_WIDTH + 2) begin : g_bad_ncw
    $error("num_cycles field does not fit the command");
  end
  if (MAX_WR_CYCLES < 2) begin : g_bad_max
    $error("MAX_WR_CYCLES must be at least 2");
  end

  typedef enum logic {
    S_IDLE,
    S_DATA
  } state_e;

  localparam logic [2:0] T_MULTI  = 3'd1;
  localparam logic [2:0] T_SINGLE = 3'd2;

  localparam logic [1:0] C_IDLE  = 2'd0;
  localparam logic [1:0] C_VALID = 2'd1;
  localparam logic [1:0] C_DONE  = 2'd2;

  localparam logic [1:0] E_EARLY  = 2'd1;
  localparam logic [1:0] E_NODONE = 2'd2;
  localparam logic [1:0] E_BAD    = 2'd3;

  localparam logic [NCW:0] N_MAX = (NCW+1)'(MAX_WR_CYCLES);

  state_e            state_q, state_d;
  logic [NCW-1:0]    cnt_q, cnt_d;
  logic [NCW:0]      n_q, n_d;
  logic [2:0]        typ_q, typ_d;
  logic [DW-1:0]     buf_q, buf_d;

  logic              ovld_q, ovld_d;
  logic [DW-1:0]     odat_q, odat_d;
  logic [NCW:0]      onum_q, onum_d;
  logic [2:0]        otyp_q, otyp_d;

  logic              wdone_q, wdone_d;
  logic              err_q, err_d;
  logic [1:0]        code_q, code_d;
  logic              ovf_q, ovf_d;

  logic              cmd_v;
  logic [NCW-1:0]    cmd_num;
  logic [2:0]        cmd_t;
  logic [1:0]        ctype;
  logic [WR_WIDTH-1:0] beat;
  logic [NCW:0]      cmd_n;
  logic              last;
  logic              drain;
  logic              store;
  logic              done_ok;

  assign cmd_v   = in_cyc[WR_WIDTH+1];
  assign cmd_num = in_cyc[NCW+2:3];
  assign cmd_t   = in_cyc[2:0];
  assign ctype   = in_cyc[WR_WIDTH+1 -: 2];
  assign beat    = in_cyc[WR_WIDTH-1:0];

  // Zero (and anything past the buffer depth) selects a full-length write
  assign cmd_n = (cmd_num == '0 || {1'b0, cmd_num} > N_MAX)
               ? N_MAX : {1'b0, cmd_num};
  assign last  = ({1'b0, cnt_q} == n_q - 1'b1);
  assign drain = ovld_q & wr_rdy;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    typ_d   = typ_q;
    buf_d   = buf_q;
    ovld_d  = ovld_q;
    odat_d  = odat_q;
    onum_d  = onum_q;
    otyp_d  = otyp_q;
    err_d   = 1'b0;
    code_d  = 2'd0;
    ovf_d   = 1'b0;
    store   = 1'b0;
    done_ok = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_v) begin
          if (cmd_t > T_SINGLE) begin
            err_d  = 1'b1;
            code_d = E_BAD;
          end else begin
            state_d = S_DATA;
            n_d     = cmd_n;
            typ_d   = cmd_t;
            cnt_d   = '0;
            buf_d   = '0;
          end
        end
      end
      S_DATA: begin
        unique case (ctype)
          C_IDLE: ;
          C_VALID: begin
            if (last) begin
              err_d   = 1'b1;
              code_d  = E_NODONE;
              state_d = S_IDLE;
            end else begin
              store = 1'b1;
              cnt_d = cnt_q + 1'b1;
            end
          end
          C_DONE: begin
            state_d = S_IDLE;
            if (last) begin
              store   = 1'b1;
              done_ok = 1'b1;
            end else begin
              err_d  = 1'b1;
              code_d = E_EARLY;
            end
          end
          default: begin
            err_d   = 1'b1;
            code_d  = E_BAD;
            state_d = S_IDLE;
          end
        endcase
      end
    endcase

    if (store) begin
      buf_d[int'(cnt_q)*WR_WIDTH +: WR_WIDTH] = beat;
    end

    // A full, non-draining output register keeps its write
    if (done_ok) begin
      if (ovld_q && !wr_rdy) begin
        ovf_d = 1'b1;
      end else begin
        ovld_d = 1'b1;
        odat_d = buf_d;
        onum_d = n_q;
        otyp_d = typ_q;
      end
    end else if (drain) begin
      ovld_d = 1'b0;
    end

    wdone_d = (store && typ_q == T_MULTI) ||
              (drain && otyp_q == T_SINGLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      typ_q   <= '0;
      buf_q   <= '0;
      ovld_q  <= 1'b0;
      odat_q  <= '0;
      onum_q  <= '0;
      otyp_q  <= '0;
      wdone_q <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      typ_q   <= typ_d;
      buf_q   <= buf_d;
      ovld_q  <= ovld_d;
      odat_q  <= odat_d;
      onum_q  <= onum_d;
      otyp_q  <= otyp_d;
      wdone_q <= wdone_d;
      err_q   <= err_d;
      code_q  <= code_d;
      ovf_q   <= ovf_d;
    end
  end

  assign wr_vld        = ovld_q;
  assign wr_dat        = odat_q;
  assign wr_num_cycles = onum_q;
  assign wr_type       = otyp_q;
  assign wdone         = wdone_q;
  assign err           = err_q;
  assign err_code      = code_q;
  assign ovf           = ovf_q;

endmodule

// File: tb/tb_pipelined_write_rx.sv
// Scoreboard bench for pipelined_write_rx: transaction-level reference
// model feeds expected writes/errors, a monitor pops them on DUT outputs.
module tb_pipelined_write_rx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [9:0]   a_in;
  logic         a_rdy, a_vld, a_wd, a_err, a_ovf;
  logic [31:0]  a_dat;
  logic [2:0]   a_num, a_typ;
  logic [1:0]   a_code;

  logic [17:0]  b_in;
  logic         b_rdy, b_vld, b_wd, b_err, b_ovf;
  logic [127:0] b_dat;
  logic [3:0]   b_num;
  logic [2:0]   b_typ;
  logic [1:0]   b_code;

  pipelined_write_rx #(.WR_WIDTH(8), .MAX_WR_CYCLES(4)) u_a (
    .clk(clk), .rst(rst), .in_cyc(a_in),
    .wr_vld(a_vld), .wr_rdy(a_rdy), .wr_dat(a_dat),
    .wr_num_cycles(a_num), .wr_type(a_typ), .wdone(a_wd),
    .err(a_err), .err_code(a_code), .ovf(a_ovf)
  );

  pipelined_write_rx #(.WR_WIDTH(16), .MAX_WR_CYCLES(8)) u_b (
    .clk(clk), .rst(rst), .in_cyc(b_in),
    .wr_vld(b_vld), .wr_rdy(b_rdy), .wr_dat(b_dat),
    .wr_num_cycles(b_num), .wr_type(b_typ), .wdone(b_wd),
    .err(b_err), .err_code(b_code), .ovf(b_ovf)
  );

  typedef struct {
    logic [31:0] dat;
    int          num;
    int          typ;
  } wr_t;

  int  n_chk = 0;
  int  n_err = 0;
  wr_t exp_wr[$];
  int  exp_errq[$];
  int  exp_wd = 0, got_wd = 0;
  int  exp_ovf = 0, got_ovf = 0;
  int  b_errs = 0;

  // Reference model state: open write as a beat list, held output flag
  bit          m_in;
  int          m_n, m_t;
  logic [7:0]  m_beats[$];
  bit          m_held;
  int          m_ht;

  task automatic chk(string nm, logic [127:0] got, logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic void model(logic [9:0] c, logic r);
    bit  drain = m_held && r;
    bit  comp  = 0;
    bit  wd    = 0;
    wr_t w;
    if (drain && m_ht == 2) wd = 1;
    if (!m_in) begin
      if (c[9]) begin
        if (c[2:0] > 3'd2) exp_errq.push_back(3);
        else begin
          m_in = 1;
          m_n  = (c[4:3] == 2'd0) ? 4 : int'(c[4:3]);
          m_t  = int'(c[2:0]);
          m_beats.delete();
        end
      end
    end else begin
      bit last = (m_beats.size() == m_n - 1);
      case (c[9:8])
        2'd1: begin
          if (last) begin
            exp_errq.push_back(2);
            m_in = 0;
          end else begin
            m_beats.push_back(c[7:0]);
            if (m_t == 1) wd = 1;
          end
        end
        2'd2: begin
          m_in = 0;
          if (last) begin
            m_beats.push_back(c[7:0]);
            if (m_t == 1) wd = 1;
            comp = 1;
          end else exp_errq.push_back(1);
        end
        2'd3: begin
          exp_errq.push_back(3);
          m_in = 0;
        end
        default: ;
      endcase
    end
    if (comp) begin
      if (m_held && !drain) exp_ovf++;
      else begin
        w.dat = '0;
        foreach (m_beats[i]) w.dat[i*8 +: 8] = m_beats[i];
        w.num = m_n;
        w.typ = m_t;
        exp_wr.push_back(w);
        m_held = 1;
        m_ht   = m_t;
      end
    end else if (drain) m_held = 0;
    if (wd) exp_wd++;
  endfunction

  task automatic step(logic [9:0] c, logic r);
    @(posedge clk);
    #1;
    a_in  = c;
    a_rdy = r;
    model(c, r);
  endtask

  task automatic stepb(logic [17:0] c, logic r);
    @(posedge clk);
    #1;
    b_in  = c;
    b_rdy = r;
  endtask

  wr_t mw;
  int  mc;
  always @(negedge clk) begin
    if (!rst) begin
      if (a_vld && a_rdy) begin
        if (exp_wr.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_write: got dat %0h expected none", a_dat);
        end else begin
          mw = exp_wr.pop_front();
          chk("wr_dat", a_dat, mw.dat);
          chk("wr_num_cycles", a_num, mw.num);
          chk("wr_type", a_typ, mw.typ);
        end
      end
      if (a_err) begin
        if (exp_errq.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_err: got code %0d expected none", a_code);
        end else begin
          mc = exp_errq.pop_front();
          chk("err_code", a_code, mc);
        end
      end
      if (a_wd) got_wd++;
      if (a_ovf) got_ovf++;
      if (b_err) b_errs++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] eb;
    rst = 1'b1;
    a_in = '0; a_rdy = 1'b0;
    b_in = '0; b_rdy = 1'b0;
    m_in = 0; m_held = 0; m_n = 0; m_t = 0; m_ht = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_vld", a_vld, 0);
    chk("rst_dat", a_dat, 0);
    chk("rst_num", a_num, 0);
    chk("rst_typ", a_typ, 0);
    chk("rst_pulses", {a_wd, a_err, a_code, a_ovf}, 0);
    chk("rst_b_vld", b_vld, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Full-length SINGLE write
    step(10'h202, 1);
    step(10'h111, 1);
    step(10'h122, 1);
    step(10'h133, 1);
    step(10'h244, 1);
    step(10'h000, 1);
    @(negedge clk);
    chk("t1_vld_up", a_vld, 1);
    step(10'h000, 1);
    @(negedge clk);
    chk("t1_vld_down", a_vld, 0);
    chk("t1_wdone", a_wd, 1);

    // MULTI write with bubbles
    step(10'h211, 1);
    step(10'h1AA, 1);
    step(10'h000, 1);
    step(10'h000, 1);
    step(10'h2BB, 1);
    repeat (3) step(10'h000, 1);

    // Early DONE, then missing DONE
    step(10'h218, 1);
    step(10'h101, 1);
    step(10'h202, 1);
    step(10'h000, 1);
    step(10'h218, 1);
    step(10'h101, 1);
    step(10'h102, 1);
    step(10'h103, 1);
    repeat (2) step(10'h000, 1);

    // Invalid type, then a normal write
    step(10'h205, 1);
    step(10'h000, 1);
    step(10'h208, 1);
    step(10'h2CC, 1);
    repeat (2) step(10'h000, 1);

    // Backpressure: hold, overflow, then load while draining
    step(10'h208, 0);
    step(10'h201, 0);
    step(10'h208, 0);
    step(10'h202, 0);
    step(10'h208, 0);
    step(10'h203, 1);
    step(10'h000, 1);
    @(negedge clk);
    chk("t5_vld_stays", a_vld, 1);
    chk("t5_third_dat", a_dat, 32'h03);
    repeat (2) step(10'h000, 1);

    for (int t = 0; t < 400; t++) begin
      int   num, ty, n;
      logic [1:0] ct;
      repeat ($urandom_range(0, 2))
        step({1'b0, 9'($urandom)}, $urandom_range(0, 3) != 0);
      num = $urandom_range(0, 3);
      ty  = ($urandom_range(0, 9) == 0) ? $urandom_range(3, 7)
                                        : $urandom_range(0, 2);
      step({1'b1, 4'($urandom), 2'(num), 3'(ty)}, $urandom_range(0, 3) != 0);
      n = (num == 0) ? 4 : num;
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2))
          step({2'b00, 8'($urandom)}, $urandom_range(0, 3) != 0);
        ct = (i == n - 1) ? 2'd2 : 2'd1;
        if ($urandom_range(0, 14) == 0) ct = 2'($urandom_range(1, 3));
        step({ct, 8'($urandom)}, $urandom_range(0, 3) != 0);
      end
    end
    repeat (6) step(10'h000, 1);
    @(negedge clk);
    chk("writes_left", exp_wr.size(), 0);
    chk("errs_left", exp_errq.size(), 0);
    chk("wdone_count", got_wd, exp_wd);
    chk("ovf_count", got_ovf, exp_ovf);

    // Wide config: reset mid-write, then a full 8-beat write
    stepb(18'h20000, 1);
    stepb(18'h10001, 1);
    stepb(18'h10002, 1);
    stepb(18'h00000, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("b_rst_vld", b_vld, 0);
    chk("b_rst_dat", b_dat, 0);
    chk("b_rst_num_typ", {b_num, b_typ}, 0);
    chk("b_rst_pulses", {b_wd, b_err, b_code, b_ovf}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    stepb(18'h20000, 1);
    eb = '0;
    for (int i = 0; i < 8; i++) begin
      logic [15:0] d;
      d = 16'h1111 * 16'(i + 1);
      eb[i*16 +: 16] = d;
      stepb({(i == 7) ? 2'b10 : 2'b01, d}, 1);
    end
    stepb(18'h00000, 1);
    @(negedge clk);
    chk("b_vld", b_vld, 1);
    chk("b_dat", b_dat, eb);
    chk("b_num", b_num, 8);
    chk("b_typ", b_typ, 0);
    stepb(18'h00000, 1);
    @(negedge clk);
    chk("b_no_err", b_errs, 0);
    chk("b_vld_down", b_vld, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
